// File: rtl/uart_alu_sequencer.sv
// Command sequencer between UART RX/TX and the ALU: collects opcode/A/B frames, sends one result byte.
// Optional inter-byte timeout in WAIT_A/WAIT_B is built when UART_ALU_SEQ_TIMEOUT_EN is defined.
module uart_alu_sequencer #(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned NB_OP        = 6,
  parameter int unsigned TIMEOUT_CLKS = 500000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitA,
    StWaitB,
    StExec,
    StWaitTx
  } state_e;

  state_e state_q;

  // Upper opcode bits must be zero; the low bits select one of eight ALU functions.
  function automatic logic is_valid_op(input logic [NB_DATA-1:0] b);
    if (b[NB_DATA-1:NB_OP] != '0) return 1'b0;
    case (b[NB_OP-1:0])
      NB_OP'('h20), NB_OP'('h22), NB_OP'('h24), NB_OP'('h25),
      NB_OP'('h26), NB_OP'('h03), NB_OP'('h02), NB_OP'('h27): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic in_wait;
  logic tmo_hit;
  assign in_wait = (state_q == StWaitA) || (state_q == StWaitB);

`ifdef UART_ALU_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);
  logic [TmoW-1:0] tmo_q;
  assign tmo_hit = in_wait && (tmo_q == TmoW'(TIMEOUT_CLKS));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_rx_done || !in_wait) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_rx_done) begin
            if (is_valid_op(i_rx_data)) begin
              o_alu_op <= i_rx_data[NB_OP-1:0];
              state_q  <= StWaitA;
              o_busy   <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        StWaitA: begin
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            state_q <= StWaitB;
          end else if (tmo_hit) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
            o_err   <= 1'b1;
          end
        end
        StWaitB: begin
          if (i_rx_done) begin
            o_alu_b <= i_rx_data;
            state_q <= StExec;
          end else if (tmo_hit) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
            o_err   <= 1'b1;
          end
        end
        StExec: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          o_err      <= i_rx_done;
          state_q    <= StWaitTx;
        end
        StWaitTx: begin
          o_err <= i_rx_done;
          // A done pulse coincident with our own start belongs to an earlier transfer.
          if (i_tx_done && !o_tx_start) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
